// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - streams a register index range out of the register file read port
module regfile_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_idx,
    input  logic [ADDR_W-1:0] last_idx,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic              rf_hold,
    output logic              busy,
    output logic              done,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W-1:0] m_index,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W-1:0]   r_end;
    logic                r_m_valid;
    logic [ADDR_W-1:0]   r_m_index;
    logic [DATA_W-1:0]   r_m_data;
    logic                r_m_last;
    logic                r_done;

    logic                w_accept;
    logic                w_load;
    logic                w_at_end;
    logic                w_drain_done;
    logic [ADDR_W-1:0]   w_ptr_inc;

    // Pointer increment wraps modulo NUM_REGS, which need not be a power of two.
    assign w_ptr_inc = (r_ptr == ADDR_W'(NUM_REGS - 1)) ? '0 : r_ptr + 1'b1;

    // State register; reset abandons any dump in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_load       = 1'b0;
        w_drain_done = 1'b0;
        w_at_end     = (r_ptr == r_end);
        rf_addr      = '0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                rf_addr = r_ptr;
                // Output register is free when empty or being drained this edge.
                if (!r_m_valid || m_ready) begin
                    w_load = 1'b1;
                    if (w_at_end) begin
                        w_next_state = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (m_ready) begin
                    w_drain_done = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Range pointers: latched on an accepted start, advanced on each loaded beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
            r_end <= '0;
        end else if (w_accept) begin
            r_ptr <= first_idx;
            r_end <= last_idx;
        end else if (w_load && !w_at_end) begin
            r_ptr <= w_ptr_inc;
        end
    end

    // Output beat register and done pulse; x0 is forced to read as zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m_valid <= 1'b0;
            r_m_index <= '0;
            r_m_data  <= '0;
            r_m_last  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_drain_done;
            if (w_load) begin
                r_m_valid <= 1'b1;
                r_m_index <= r_ptr;
                r_m_data  <= (r_ptr == '0) ? '0 : rf_data;
                r_m_last  <= w_at_end;
            end else if (w_drain_done) begin
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
            end
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign rf_hold = busy;
    assign done    = r_done;
    assign m_valid = r_m_valid;
    assign m_index = r_m_index;
    assign m_data  = r_m_data;
    assign m_last  = r_m_last;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb/tb_regfile_dump_reader.sv - self-checking bench for regfile_dump_reader
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  first_idx;
    logic [4:0]  last_idx;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        rf_hold;
    logic        busy;
    logic        done;
    logic        m_valid;
    logic        m_ready;
    logic [4:0]  m_index;
    logic [31:0] m_data;
    logic        m_last;

    logic [31:0] regs [32];
    bit          force_dead;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t expq[$];
    int    ready_pat[$];
    int    ready_pct;

    regfile_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .first_idx (first_idx),
        .last_idx  (last_idx),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .rf_hold   (rf_hold),
        .busy      (busy),
        .done      (done),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_index   (m_index),
        .m_data    (m_data),
        .m_last    (m_last)
    );

    assign rf_data = force_dead ? 32'hDEADBEEF : regs[rf_addr];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: beat k of a dump is index (first+k) mod 32, x0 reads zero.
    task automatic build(input int f, input int l);
        int n;
        beat_t b;
        n = ((l - f + 32) % 32) + 1;
        expq.delete();
        for (int k = 0; k < n; k++) begin
            b.idx  = 5'((f + k) % 32);
            b.data = (b.idx == 5'd0) ? 32'd0 : (force_dead ? 32'hDEADBEEF : regs[b.idx]);
            b.last = (k == n - 1);
            expq.push_back(b);
        end
    endtask

    task automatic start_dump(input int f, input int l);
        @(negedge clk);
        first_idx = 5'(f);
        last_idx  = 5'(l);
        start     = 1'b1;
        build(f, l);
        @(negedge clk);
        start = 1'b0;
        chk("no_beat_on_start", 32'(m_valid), 32'd0);
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("rf_addr_first", 32'(rf_addr), 32'(f));
    endtask

    task automatic consume(input bit check_cycles);
        int k;
        int cyc;
        int n;
        k   = 0;
        cyc = 0;
        n   = expq.size();
        while (k < n && cyc < 2000) begin
            if (ready_pat.size() > 0) m_ready = (ready_pat.pop_front() != 0);
            else                      m_ready = ($urandom_range(99) < ready_pct);
            chk("busy_run", 32'(busy), 32'd1);
            chk("hold_eq_busy", 32'(rf_hold), 32'(busy));
            chk("done_low_run", 32'(done), 32'd0);
            if (m_valid) begin
                chk("beat_index", 32'(m_index), 32'(expq[k].idx));
                chk("beat_data", m_data, expq[k].data);
                chk("beat_last", 32'(m_last), 32'(expq[k].last));
            end
            if (m_valid && m_ready) k++;
            cyc++;
            @(negedge clk);
        end
        if (k < n) chk("beat_timeout", 32'(k), 32'(n));
        if (check_cycles) chk("busy_cycles", 32'(cyc), 32'(n + 1));
        chk("done_pulse", 32'(done), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_hold", 32'(rf_hold), 32'd0);
        chk("valid_drop", 32'(m_valid), 32'd0);
        chk("last_drop", 32'(m_last), 32'd0);
        m_ready = $urandom_range(1);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        m_ready    = 1'b0;
        first_idx  = '0;
        last_idx   = '0;
        force_dead = 1'b0;
        ready_pct  = 100;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        regs[5] = 32'd6;
        regs[9] = 32'h2004;
        #12;
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hold", 32'(rf_hold), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rf_addr", 32'(rf_addr), 32'd0);
        chk("rst_index", 32'(m_index), 32'd0);
        chk("rst_data", m_data, 32'd0);
        chk("rst_last", 32'(m_last), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Full dump, sustained ready.
        ready_pct = 100;
        start_dump(0, 31);
        consume(1'b1);

        // Single register.
        start_dump(9, 9);
        consume(1'b1);

        // Wrap through 31 -> 0.
        regs[30] = 32'hAAAA0030;
        regs[31] = 32'hAAAA0031;
        regs[1]  = 32'h11;
        start_dump(30, 1);
        consume(1'b1);

        // Fixed backpressure pattern.
        ready_pat = '{0, 0, 1, 0, 1, 1};
        start_dump(4, 6);
        consume(1'b0);

        // x0 masking with garbage read data.
        force_dead = 1'b1;
        start_dump(0, 0);
        consume(1'b1);
        force_dead = 1'b0;

        // Randomized contents, ranges and backpressure.
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        ready_pct = 60;
        for (int t = 0; t < 8; t++) begin
            start_dump($urandom_range(31), $urandom_range(31));
            consume(1'b0);
        end

        // Abort mid-dump with asynchronous reset.
        ready_pct = 100;
        start_dump(0, 31);
        m_ready = 1'b1;
        repeat (11) @(negedge clk);
        chk("pre_abort_index", 32'(m_index), 32'd10);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_valid", 32'(m_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hold", 32'(rf_hold), 32'd0);
        @(negedge clk);
        rst     = 1'b1;
        m_ready = 1'b0;

        // Fresh dump under stall; a start while busy must be ignored.
        start_dump(0, 2);
        @(negedge clk);
        chk("restart_valid", 32'(m_valid), 32'd1);
        chk("restart_index", 32'(m_index), 32'd0);
        first_idx = 5'd5;
        last_idx  = 5'd5;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        consume(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
